// File: rtl/mul_div_if.sv
// Issue/result bundle between decode/controller and the iterative multiply/divide unit.
// The controller drives start/op/a/b and reads busy, done, div_zero, hi and lo.
interface mul_div_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, done, div_zero, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit that owns HI/LO and also services MTHI/MTLO.
// Operands are reduced to magnitudes on issue; signs are reapplied in the single FIX cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    mul_div_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opd_b;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   acc;        // product high half / partial remainder
    logic [WIDTH-1:0]   q;          // multiplier bits / dividend bits, becoming product low / quotient
    logic               is_div, neg_q, neg_r, dz;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, dz_q;

    logic               accept, go, op_valid, signed_op, sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     add_sum, sub_shift, sub_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = RUN;
            RUN:     if (cnt == CW'(1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs and issue decode
    always_comb begin
        bus.busy = (state != IDLE);
        accept   = bus.start && (state == IDLE);
        op_valid = (bus.op <= 3'b101);
        go       = accept && !bus.op[2];
    end

    // Operand conditioning: op[0]=0 selects the signed variants
    always_comb begin
        signed_op = !bus.op[0];
        sa        = signed_op && bus.a[WIDTH-1];
        sb        = signed_op && bus.b[WIDTH-1];
        abs_a     = sa ? -bus.a : bus.a;
        abs_b     = sb ? -bus.b : bus.b;
    end

    // One iteration step; the add/sub is WIDTH+1 wide so carry/borrow is kept
    always_comb begin
        add_sum   = {1'b0, acc} + (q[0] ? {1'b0, opd_b} : '0);
        sub_shift = {acc, q[WIDTH-1]};
        sub_diff  = sub_shift - {1'b0, opd_b};
        prod      = neg_q ? -{acc, q} : {acc, q};
        if (is_div) begin
            res_hi = neg_r ? -acc : acc;
            res_lo = dz ? '1 : (neg_q ? -q : q);
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            opd_b  <= '0;
            acc    <= '0;
            q      <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept && op_valid) dz_q <= 1'b0;
            if (accept && bus.op == 3'b100) hi_q <= bus.a;
            if (accept && bus.op == 3'b101) lo_q <= bus.a;
            if (go) begin
                is_div <= bus.op[1];
                neg_q  <= sa ^ sb;
                neg_r  <= sa;
                dz     <= bus.op[1] && (bus.b == '0);
                opd_b  <= abs_b;
                acc    <= '0;
                q      <= abs_a;
                cnt    <= CW'(WIDTH);
            end
            case (state)
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        // Restoring: keep the difference only when it did not borrow
                        if (!sub_diff[WIDTH]) begin
                            acc <= sub_diff[WIDTH-1:0];
                            q   <= {q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= sub_shift[WIDTH-1:0];
                            q   <= {q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= add_sum[WIDTH:1];
                        q   <= {add_sum[0], q[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                    dz_q   <= dz;
                end
                default: ;
            endcase
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
endmodule
